// File: rtl/key_command_queue.sv
// key_command_queue
//   Maps KeyboardDecoder make/break events onto NUM_KEYS configurable scan codes,
//   tracks a held level per key, and produces move commands on each fresh make and
//   on auto-repeat of the most recently pressed repeatable key. Commands are queued
//   in a first-word-fall-through FIFO that the game logic pops with valid/ready.
//
// Ports
//   clk          system clock
//   rst          synchronous active-high reset
//   key_down     held-key vector from KeyboardDecoder, indexed by scan code
//   last_change  scan code of the most recent event
//   key_valid    one-cycle event strobe
//   held         per-key held level
//   cmd_valid    FIFO non-empty
//   cmd_id       head command id (zero while cmd_valid is low)
//   cmd_ready    consumer pop request; pop happens on cmd_valid & cmd_ready
//   fifo_count   current FIFO occupancy
//   overflow     sticky flag, set when a command had to be dropped
//
// Repeat tracker states
//   state      | meaning
//   TRK_IDLE   | no key is auto-repeating
//   TRK_ACTIVE | timer counts down; at terminal count rep_key is pushed and
//              | the timer reloads with REPEAT_PERIOD

module key_command_queue #(
    parameter int                    NUM_KEYS      = 5,
    parameter logic [NUM_KEYS*9-1:0] KEY_CODES     = {9'h05A, 9'h023, 9'h01B, 9'h01C, 9'h01D},
    parameter logic [NUM_KEYS-1:0]   REPEAT_MASK   = 5'b01111,
    parameter int                    REPEAT_DELAY  = 50_000_000,
    parameter int                    REPEAT_PERIOD = 10_000_000,
    parameter int                    FIFO_DEPTH    = 4,
    parameter int                    IDW           = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [511:0]                  key_down,
    input  logic [8:0]                    last_change,
    input  logic                          key_valid,
    output logic [NUM_KEYS-1:0]           held,
    output logic                          cmd_valid,
    output logic [IDW-1:0]                cmd_id,
    input  logic                          cmd_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = 32;

    typedef enum logic {
        TRK_IDLE,
        TRK_ACTIVE
    } trk_state_t;

    // ------------------------------------------------------------------
    // Event decode. Scanning from the top index down lets the lowest
    // matching index overwrite any higher duplicate.
    // ------------------------------------------------------------------
    logic [NUM_KEYS-1:0] hit_oh;
    logic [IDW-1:0]      hit_idx;
    logic                hit;

    always_comb begin
        hit_oh  = '0;
        hit_idx = '0;
        hit     = 1'b0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (KEY_CODES[i*9 +: 9] == last_change) begin
                hit_oh    = '0;
                hit_oh[i] = 1'b1;
                hit_idx   = IDW'(i);
                hit       = 1'b1;
            end
        end
    end

    logic is_make;
    logic make_new;
    logic brk;
    logic make_rep;

    assign is_make  = key_down[last_change];
    // A make for a key that is already held is a typematic re-send: ignored.
    assign make_new = key_valid & hit & is_make & ~(|(held & hit_oh));
    assign brk      = key_valid & hit & ~is_make;
    assign make_rep = make_new & (|(hit_oh & REPEAT_MASK));

    always_ff @(posedge clk) begin
        if (rst) begin
            held <= '0;
        end else if (make_new) begin
            held <= held | hit_oh;
        end else if (brk) begin
            held <= held & ~hit_oh;
        end
    end

    // ------------------------------------------------------------------
    // Repeat tracker
    // ------------------------------------------------------------------
    trk_state_t     trk_state, trk_next;
    logic [TW-1:0]  timer, timer_next;
    logic [IDW-1:0] rep_key, rep_key_next;
    logic           rep_fire;

    always_ff @(posedge clk) begin
        if (rst) begin
            trk_state <= TRK_IDLE;
            timer     <= '0;
            rep_key   <= '0;
        end else begin
            trk_state <= trk_next;
            timer     <= timer_next;
            rep_key   <= rep_key_next;
        end
    end

    always_comb begin
        trk_next     = trk_state;
        timer_next   = timer;
        rep_key_next = rep_key;
        rep_fire     = 1'b0;
        case (trk_state)
            TRK_IDLE: begin
            end
            TRK_ACTIVE: begin
                if (timer == TW'(1)) begin
                    rep_fire   = 1'b1;
                    timer_next = TW'(REPEAT_PERIOD);
                end else begin
                    timer_next = timer - TW'(1);
                end
            end
            default: trk_next = TRK_IDLE;
        endcase
        // Releasing the tracked key stops repeating; other held keys do not take over.
        if (brk && (trk_state == TRK_ACTIVE) && (hit_idx == rep_key)) begin
            trk_next = TRK_IDLE;
        end
        // The newest repeatable make always retargets the tracker.
        if (make_rep) begin
            trk_next     = TRK_ACTIVE;
            timer_next   = TW'(REPEAT_DELAY);
            rep_key_next = hit_idx;
        end
    end

    // ------------------------------------------------------------------
    // Command FIFO (first-word-fall-through)
    // ------------------------------------------------------------------
    logic [IDW-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [CW-1:0]  count;
    logic           push_req;
    logic [IDW-1:0] push_id;
    logic           pop;
    logic           full;
    logic           do_push;

    // A make push pre-empts a coincident repeat push; the repeat is simply lost.
    assign push_req = make_new | rep_fire;
    assign push_id  = make_new ? hit_idx : rep_key;

    assign cmd_valid = (count != '0);
    assign full      = (count == CW'(FIFO_DEPTH));
    assign pop       = cmd_valid & cmd_ready;
    // At full, a simultaneous pop frees the slot the push needs.
    assign do_push   = push_req & (~full | pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(do_push) - CW'(pop);
            if (push_req && full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_id;
        end
    end

    assign cmd_id     = cmd_valid ? mem[rd_ptr] : '0;
    assign fifo_count = count;

endmodule

// File: tb/tb_key_command_queue.sv
module tb_key_command_queue;

    localparam int NK     = 5;
    localparam int DELAY  = 20;
    localparam int PERIOD = 8;
    localparam int DEPTH  = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [511:0] kd = '0;
    logic [8:0]   last_change = '0;
    logic         key_valid = 1'b0;
    logic [NK-1:0] held;
    logic         cmd_valid;
    logic [3:0]   cmd_id;
    logic         cmd_ready = 1'b0;
    logic [2:0]   fifo_count;
    logic         overflow;

    key_command_queue #(
        .REPEAT_DELAY (DELAY),
        .REPEAT_PERIOD(PERIOD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .key_down   (kd),
        .last_change(last_change),
        .key_valid  (key_valid),
        .held       (held),
        .cmd_valid  (cmd_valid),
        .cmd_id     (cmd_id),
        .cmd_ready  (cmd_ready),
        .fifo_count (fifo_count),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int           codes [NK] = '{'h1D, 'h1C, 'h1B, 'h23, 'h5A};
    logic [NK-1:0] rmask = 5'b01111;

    logic [NK-1:0] m_held = '0;
    int            mq [$];
    bit            m_ovf = 0;
    bit            m_rep_on = 0;
    int            m_rep_key = 0;
    longint        m_rep_due = 0;
    bit            m_live = 0;
    longint        cyc = 0;

    bit m_pop, m_fire, m_mk;
    int m_pid, m_hit;

    always @(posedge clk) begin
        if (rst) begin
            m_held   = '0;
            mq.delete();
            m_ovf    = 0;
            m_rep_on = 0;
            m_live   = 1;
        end else begin
            m_pop  = (mq.size() > 0) && cmd_ready;
            m_fire = m_rep_on && (cyc == m_rep_due);
            m_mk   = 0;
            m_pid  = 0;
            m_hit  = -1;
            if (key_valid) begin
                for (int i = NK - 1; i >= 0; i--)
                    if (codes[i] == int'(last_change)) m_hit = i;
            end
            if (m_hit >= 0) begin
                if (kd[last_change]) begin
                    if (!m_held[m_hit]) begin
                        m_held[m_hit] = 1'b1;
                        m_mk  = 1;
                        m_pid = m_hit;
                    end
                end else begin
                    m_held[m_hit] = 1'b0;
                    if (m_rep_on && m_rep_key == m_hit) m_rep_on = 0;
                end
            end
            if (m_fire) m_rep_due = cyc + PERIOD;
            if (m_pop) void'(mq.pop_front());
            if (m_mk || m_fire) begin
                if (mq.size() < DEPTH) mq.push_back(m_mk ? m_pid : m_rep_key);
                else m_ovf = 1;
            end
            if (m_mk && rmask[m_pid]) begin
                m_rep_on  = 1;
                m_rep_key = m_pid;
                m_rep_due = cyc + DELAY;
            end
        end
        cyc++;
    end

    // ---------------- compare process + pop log ----------------
    longint log_t [$];
    int     log_id [$];

    always @(negedge clk) begin
        if (m_live) begin
            check("held",       32'(held),       32'(m_held));
            check("cmd_valid",  32'(cmd_valid),  32'(mq.size() > 0));
            check("cmd_id",     32'(cmd_id),     (mq.size() > 0) ? 32'(mq[0]) : 32'd0);
            check("fifo_count", 32'(fifo_count), 32'(mq.size()));
            check("overflow",   32'(overflow),   32'(m_ovf));
            if (cmd_valid === 1'b1 && cmd_ready) begin
                log_t.push_back(cyc - 1);
                log_id.push_back(int'(cmd_id));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic ev(input logic [8:0] code, input logic mk);
        kd[code]    = mk;
        last_change = code;
        key_valid   = 1'b1;
        tick(1);
        key_valid   = 1'b0;
    endtask

    task automatic clear_log();
        log_t.delete();
        log_id.delete();
    endtask

    initial begin
        // 1: reset and a single make/pop
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        @(negedge clk);
        check("rst_held",  32'(held), 32'd0);
        check("rst_valid", 32'(cmd_valid), 32'd0);
        check("rst_id",    32'(cmd_id), 32'd0);
        check("rst_count", 32'(fifo_count), 32'd0);
        check("rst_ovf",   32'(overflow), 32'd0);
        ev(9'h01D, 1'b1);
        @(negedge clk);
        check("t1_held",  32'(held), 32'h01);
        check("t1_valid", 32'(cmd_valid), 32'd1);
        check("t1_id",    32'(cmd_id), 32'd0);
        cmd_ready = 1'b1;
        tick(1);
        cmd_ready = 1'b0;
        @(negedge clk);
        check("t1_pop_valid", 32'(cmd_valid), 32'd0);
        check("t1_pop_count", 32'(fifo_count), 32'd0);
        ev(9'h01D, 1'b0);
        tick(2);

        // 2: auto-repeat timing on D
        cmd_ready = 1'b1;
        clear_log();
        ev(9'h023, 1'b1);
        tick(39);
        ev(9'h023, 1'b0);
        tick(30);
        check("t2_ncmd", 32'(log_t.size()), 32'd4);
        if (log_t.size() == 4) begin
            check("t2_d1", 32'(log_t[1] - log_t[0]), 32'd20);
            check("t2_d2", 32'(log_t[2] - log_t[0]), 32'd28);
            check("t2_d3", 32'(log_t[3] - log_t[0]), 32'd36);
            for (int i = 0; i < 4; i++) check("t2_id", 32'(log_id[i]), 32'd3);
        end

        // 3: typematic re-send and non-repeating Enter
        clear_log();
        ev(9'h01C, 1'b1);
        tick(3);
        ev(9'h01C, 1'b1);
        tick(3);
        ev(9'h01C, 1'b0);
        tick(5);
        check("t3_resend_n", 32'(log_id.size()), 32'd1);
        if (log_id.size() == 1) check("t3_resend_id", 32'(log_id[0]), 32'd1);
        clear_log();
        ev(9'h05A, 1'b1);
        tick(100);
        ev(9'h05A, 1'b0);
        tick(3);
        check("t3_enter_n", 32'(log_id.size()), 32'd1);
        if (log_id.size() == 1) check("t3_enter_id", 32'(log_id[0]), 32'd4);

        // 4: overflow and push+pop at full
        cmd_ready = 1'b0;
        ev(9'h01D, 1'b1);
        ev(9'h01C, 1'b1);
        ev(9'h01B, 1'b1);
        ev(9'h023, 1'b1);
        ev(9'h05A, 1'b1);
        @(negedge clk);
        check("t4_count", 32'(fifo_count), 32'd4);
        check("t4_ovf",   32'(overflow), 32'd1);
        check("t4_head",  32'(cmd_id), 32'd0);
        check("t4_held",  32'(held), 32'h1F);
        clear_log();
        ev(9'h01D, 1'b0);
        kd[9'h01D]  = 1'b1;
        last_change = 9'h01D;
        key_valid   = 1'b1;
        cmd_ready   = 1'b1;
        tick(1);
        key_valid   = 1'b0;
        @(negedge clk);
        check("t4_pp_count", 32'(fifo_count), 32'd4);
        check("t4_pp_head",  32'(cmd_id), 32'd1);
        tick(5);
        check("t4_npop", 32'(log_id.size()), 32'd5);
        if (log_id.size() == 5) begin
            check("t4_pop0", 32'(log_id[0]), 32'd0);
            check("t4_pop1", 32'(log_id[1]), 32'd1);
            check("t4_pop2", 32'(log_id[2]), 32'd2);
            check("t4_pop3", 32'(log_id[3]), 32'd3);
            check("t4_pop4", 32'(log_id[4]), 32'd0);
        end
        ev(9'h01D, 1'b0);
        ev(9'h01C, 1'b0);
        ev(9'h01B, 1'b0);
        ev(9'h023, 1'b0);
        ev(9'h05A, 1'b0);
        tick(3);

        // 5: unmatched code
        ev(9'h029, 1'b1);
        tick(2);
        ev(9'h029, 1'b0);
        @(negedge clk);
        check("t5_held",  32'(held), 32'd0);
        check("t5_count", 32'(fifo_count), 32'd0);
        check("t5_ovf",   32'(overflow), 32'd1);

        // 6: reset mid-operation
        cmd_ready = 1'b0;
        ev(9'h01D, 1'b1);
        ev(9'h01C, 1'b1);
        ev(9'h01B, 1'b1);
        tick(5);
        @(negedge clk);
        check("t6_pre_count", 32'(fifo_count), 32'd3);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        @(negedge clk);
        check("t6_held",  32'(held), 32'd0);
        check("t6_valid", 32'(cmd_valid), 32'd0);
        check("t6_id",    32'(cmd_id), 32'd0);
        check("t6_count", 32'(fifo_count), 32'd0);
        check("t6_ovf",   32'(overflow), 32'd0);
        tick(40);
        @(negedge clk);
        check("t6_norep_count", 32'(fifo_count), 32'd0);
        check("t6_norep_valid", 32'(cmd_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
